rvr32_ifq: RTL and testbench
============================

Name: rvr32_ifq

Overview:
- Instruction fetch stage with a prefetch queue, sitting directly upstream of the instruction decoder.
- Generates sequential fetch PCs, issues pipelined requests to instruction memory, and buffers returned words in order.
- Presents one instruction word plus its PC to the decoder under a valid/ready handshake.
- Handles redirects from branch/jump resolution by flushing the queue and discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- DEPTH, 4: queue entries, and also the bound on outstanding requests. Power of 2, minimum 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  when low, no new requests issue; in-flight responses still complete.
- redirect_valid  in  1  one-cycle redirect pulse from execute.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- imem_req  out  1  request valid.
- imem_addr  out  32  request word address; bits [1:0] are always 0.
- imem_gnt  in  1  memory accepts the request in this cycle (when imem_req=1).
- imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after grant.
- imem_rdata  in  32  response instruction word.
- inst_valid  out  1  queue head is valid.
- inst  out  32  head instruction word, sent to the decoder.
- inst_pc  out  32  PC of the head instruction.
- inst_ready  in  1  decoder consumes the head.

Behaviour:
- Reset values (asynchronous, rst_n=0): fetch pc = RESET_PC; queue count, read pointer, write pointer, inflight and drop counters all 0; inst_valid=0; imem_req=0; imem_addr=RESET_PC; inst and inst_pc = 0.
- State held:
  - fetch pc register.
  - DEPTH-entry FIFO of {pc, word}.
  - count (0..DEPTH).
  - inflight: granted requests whose responses will be kept.
  - drop: granted requests whose responses must be discarded.
  - pc FIFO of inflight request addresses, so each returned word is paired with its PC.
- Request issue:
  - imem_req = fetch_en & !redirect_valid & (count + inflight + drop < DEPTH).
  - imem_addr = fetch pc.
  - imem_req is combinational from registered state and these inputs; it has no path from imem_gnt.
  - Once asserted, imem_req and imem_addr hold until granted, unless a redirect or fetch_en=0 occurs.
  - On grant: fetch pc += 4 (wraps modulo 2^32) and inflight += 1.
- Response:
  - If imem_rvalid and drop > 0: discard the word, drop -= 1.
  - Otherwise, if imem_rvalid: push {oldest inflight pc, imem_rdata} into the queue, inflight -= 1.
  - The credit rule guarantees the queue is never full on a push. A response arriving with inflight=0 and drop=0 is a protocol error; it is ignored, and an assertion fires in simulation.
- Output:
  - inst_valid = (count != 0); inst and inst_pc come from the head entry, registered.
  - No bypass: a word pushed in cycle T is visible at the output no earlier than T+1.
  - Pop occurs on inst_valid & inst_ready.
  - Simultaneous push and pop leaves count unchanged.
- Redirect (redirect_valid=1 in cycle T), highest priority:
  - Queue flushed: count=0, pointers reset. A pop in cycle T has no additional effect.
  - drop <= drop + inflight - (1 if a response arrives in T, else 0); inflight <= 0. A response arriving in T is discarded.
  - fetch pc <= {redirect_pc[31:2], 2'b00}.
  - imem_req=0 in T. The earliest request to the new target is in T+1, with imem_addr = target.
  - Back-to-back redirects: the latest one wins; drop accumulates correctly.
- fetch_en=0:
  - Queue still drains and responses are still accepted.
  - Re-enabling resumes at the current fetch pc with no skipped or duplicated addresses.
- Throughput: with single-cycle memory latency and inst_ready held at 1, one instruction per cycle is sustained.
- Reset mid-operation: all counters clear immediately. Memory-side responses still pending at reset are not tracked; the memory is reset with the same rst_n.

Test Plan:
- Reset release, fetch_en=1, gnt=1 always, rvalid 1 cycle after grant, ready=1 -> addresses 0x0, 0x4, 0x8, … on consecutive cycles; inst_pc sequence matches, with the first inst_valid 2 cycles after the first grant.
- inst_ready=0, DEPTH=4 -> exactly 4 grants, count=4, imem_req stays 0. Raising ready pops one per cycle; each pop frees a credit and the next request issues.
- Memory latency 3 cycles, redirect_valid with redirect_pc=0x0000_1003 while 2 requests are in flight -> those 2 responses are discarded, the next imem_addr is 0x0000_1000, and the first inst_pc out is 0x0000_1000.
- Redirect in the same cycle as a response and a pop -> queue empty the next cycle, the response is discarded, and drop equals the remaining old in-flight count.
- Two redirects on consecutive cycles (targets 0x200, then 0x300) -> no 0x200 request is granted, and the first delivered inst_pc is 0x300.
- fetch pc 0xFFFF_FFFC granted -> next imem_addr is 0x0000_0000. fetch_en toggled low for 5 cycles mid-stream -> inst_pc sequence is contiguous with no gaps or duplicates.

Source files
------------

// File: rtl/rvr32_ifq_if.sv
// Bus bundles for the fetch queue: the instruction-memory request/response
// channel and the valid/ready channel toward the decoder.

interface rvr32_imem_if;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, output addr, input gnt, input rvalid, input rdata);
   modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

interface rvr32_inst_if;
   logic        valid;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        ready;

   modport master (output valid, output inst, output pc, input ready);
   modport slave  (input valid, input inst, input pc, output ready);
endinterface

// File: rtl/rvr32_ifq.sv
// Instruction fetch stage: sequential PC generation, credit-limited pipelined
// memory requests, in-order prefetch queue, and redirect flush with stale-response drop.

module rvr32_ifq #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          fetch_en_i,
   input  logic          redirect_valid_i,
   input  logic [31:0]   redirect_pc_i,
   rvr32_imem_if.master  imem,
   rvr32_inst_if.master  dec
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW+1:0] DEPTH_W = (CW+2)'(DEPTH);

   typedef logic [CW-1:0] cnt_t;
   typedef logic [PW-1:0] ptr_t;

   logic [31:0] pcQ, pcD;
   logic [31:0] qWordQ [DEPTH];
   logic [31:0] qPcQ   [DEPTH];
   logic [31:0] ifPcQ  [DEPTH];

   ptr_t rdPtrQ, rdPtrD, wrPtrQ, wrPtrD;
   ptr_t ifRdQ, ifRdD, ifWrQ, ifWrD;
   cnt_t countQ, countD, inflightQ, inflightD, dropQ, dropD;

   logic          grant, push, pop, dropRsp, rspTracked, reqW;
   logic [CW+1:0] creditsUsed;

   // Every queue slot is reserved at grant time, so the queue can never overflow on a push.
   assign creditsUsed = {2'b00, countQ} + {2'b00, inflightQ} + {2'b00, dropQ};
   assign reqW        = fetch_en_i & ~redirect_valid_i & (creditsUsed < DEPTH_W);
   assign grant       = reqW & imem.gnt;
   assign rspTracked  = imem.rvalid & ((dropQ != '0) | (inflightQ != '0));
   assign dropRsp     = imem.rvalid & (dropQ != '0);
   assign push        = imem.rvalid & (dropQ == '0) & (inflightQ != '0) & ~redirect_valid_i;
   assign pop         = (countQ != '0) & dec.ready & ~redirect_valid_i;

   assign imem.req  = reqW;
   assign imem.addr = pcQ;
   assign dec.valid = (countQ != '0);
   assign dec.inst  = qWordQ[rdPtrQ];
   assign dec.pc    = qPcQ[rdPtrQ];

   always_comb begin
      pcD       = pcQ;
      rdPtrD    = rdPtrQ;
      wrPtrD    = wrPtrQ;
      ifRdD     = ifRdQ;
      ifWrD     = ifWrQ;
      countD    = countQ;
      inflightD = inflightQ;
      dropD     = dropQ;

      if (redirect_valid_i) begin
         pcD       = redirect_pc_i & ~32'h3;
         rdPtrD    = '0;
         wrPtrD    = '0;
         ifRdD     = '0;
         ifWrD     = '0;
         countD    = '0;
         inflightD = '0;
         // Everything still outstanding becomes stale; a response landing now is one of them.
         dropD     = dropQ + inflightQ - cnt_t'(rspTracked);
      end else begin
         if (grant) begin
            pcD   = pcQ + 32'd4;
            ifWrD = ifWrQ + ptr_t'(1);
         end
         if (dropRsp) begin
            dropD = dropQ - cnt_t'(1);
         end
         if (push) begin
            wrPtrD = wrPtrQ + ptr_t'(1);
            ifRdD  = ifRdQ + ptr_t'(1);
         end
         if (pop) begin
            rdPtrD = rdPtrQ + ptr_t'(1);
         end
         countD    = countQ + cnt_t'(push) - cnt_t'(pop);
         inflightD = inflightQ + cnt_t'(grant) - cnt_t'(push);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcQ       <= RESET_PC;
         rdPtrQ    <= '0;
         wrPtrQ    <= '0;
         ifRdQ     <= '0;
         ifWrQ     <= '0;
         countQ    <= '0;
         inflightQ <= '0;
         dropQ     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            qWordQ[i] <= '0;
            qPcQ[i]   <= '0;
            ifPcQ[i]  <= '0;
         end
      end else begin
         pcQ       <= pcD;
         rdPtrQ    <= rdPtrD;
         wrPtrQ    <= wrPtrD;
         ifRdQ     <= ifRdD;
         ifWrQ     <= ifWrD;
         countQ    <= countD;
         inflightQ <= inflightD;
         dropQ     <= dropD;
         if (grant) begin
            ifPcQ[ifWrQ] <= pcQ;
         end
         if (push) begin
            qWordQ[wrPtrQ] <= imem.rdata;
            qPcQ[wrPtrQ]   <= ifPcQ[ifRdQ];
         end
      end
   end

   rspHasOwner: assert property (@(posedge clk) disable iff (!rst_n)
      imem.rvalid |-> ((inflightQ != '0) || (dropQ != '0)));

endmodule

// File: tb/tb_rvr32_ifq.sv
// Directed bench for rvr32_ifq with a fixed-latency in-order memory model
// and logs of granted addresses and delivered instructions.

module tb_rvr32_ifq;

   typedef struct {
      int          due;
      logic [31:0] word;
   } pend_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetchEn;
   logic        redirectValid;
   logic [31:0] redirectPc;

   rvr32_imem_if imemBus ();
   rvr32_inst_if instBus ();

   rvr32_ifq #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .fetch_en_i       (fetchEn),
      .redirect_valid_i (redirectValid),
      .redirect_pc_i    (redirectPc),
      .imem             (imemBus),
      .dec              (instBus)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   int          cycleNum;
   int          latency;
   logic        gntOn;
   int          firstGrant;
   int          firstValid;
   pend_t       pendQ[$];
   logic [31:0] grantLog[$];
   logic [31:0] pcLog[$];
   logic [31:0] instLog[$];

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return a ^ 32'hA5A5_5A5A;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // One clock cycle: entered just after a falling edge with control inputs already set.
   task automatic applyStimulus();
      pend_t p;
      #1;
      imemBus.rvalid = 1'b0;
      imemBus.rdata  = 32'h0;
      if (pendQ.size() != 0 && pendQ[0].due <= cycleNum) begin
         imemBus.rvalid = 1'b1;
         imemBus.rdata  = pendQ[0].word;
         pendQ.delete(0);
      end
      imemBus.gnt = gntOn;
      #1;
      if (imemBus.req && imemBus.gnt) begin
         grantLog.push_back(imemBus.addr);
         p.due  = cycleNum + latency;
         p.word = memWord(imemBus.addr);
         pendQ.push_back(p);
         if (firstGrant < 0) firstGrant = cycleNum;
      end
      if (instBus.valid && firstValid < 0) firstValid = cycleNum;
      if (instBus.valid && instBus.ready) begin
         pcLog.push_back(instBus.pc);
         instLog.push_back(instBus.inst);
      end
      @(negedge clk);
      cycleNum++;
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   task automatic doReset();
      rst_n = 1'b1;
      #1;
      rst_n          = 1'b0;
      fetchEn        = 1'b0;
      redirectValid  = 1'b0;
      redirectPc     = 32'h0;
      gntOn          = 1'b0;
      imemBus.gnt    = 1'b0;
      imemBus.rvalid = 1'b0;
      imemBus.rdata  = 32'h0;
      instBus.ready  = 1'b1;
      latency        = 1;
      pendQ.delete();
      grantLog.delete();
      pcLog.delete();
      instLog.delete();
      firstGrant = -1;
      firstValid = -1;
      repeat (2) @(negedge clk);
      checkOutput("rst inst_valid", 32'(instBus.valid), 32'h0);
      checkOutput("rst imem_req", 32'(imemBus.req), 32'h0);
      checkOutput("rst imem_addr", imemBus.addr, 32'h0);
      checkOutput("rst inst", instBus.inst, 32'h0);
      checkOutput("rst inst_pc", instBus.pc, 32'h0);
      rst_n    = 1'b1;
      cycleNum = 0;
   endtask

   task automatic redirectCycle(input logic [31:0] target);
      redirectValid = 1'b1;
      redirectPc    = target;
      applyStimulus();
      redirectValid = 1'b0;
   endtask

   initial begin
      rst_n         = 1'b1;
      fetchEn       = 1'b0;
      redirectValid = 1'b0;
      redirectPc    = 32'h0;
      instBus.ready = 1'b1;
      @(negedge clk);

      // Streaming at one instruction per cycle with single-cycle memory
      doReset();
      fetchEn = 1'b1;
      gntOn   = 1'b1;
      runCycles(12);
      checkOutput("stream grant count", 32'(grantLog.size()), 32'd12);
      checkOutput("stream first valid latency", 32'(firstValid - firstGrant), 32'd2);
      checkOutput("stream deliveries", 32'(pcLog.size()), 32'd10);
      for (int i = 0; i < 8; i++) begin
         if (grantLog.size() > i) checkOutput("stream addr", grantLog[i], 32'(4 * i));
         if (pcLog.size() > i) begin
            checkOutput("stream inst_pc", pcLog[i], 32'(4 * i));
            checkOutput("stream inst", instLog[i], memWord(32'(4 * i)));
         end
      end

      // Decoder stalled: exactly DEPTH grants, then credits return one per pop
      doReset();
      fetchEn       = 1'b1;
      gntOn         = 1'b1;
      instBus.ready = 1'b0;
      runCycles(10);
      checkOutput("stall grant count", 32'(grantLog.size()), 32'd4);
      checkOutput("stall imem_req", 32'(imemBus.req), 32'h0);
      checkOutput("stall inst_valid", 32'(instBus.valid), 32'h1);
      checkOutput("stall head pc", instBus.pc, 32'h0);
      instBus.ready = 1'b1;
      applyStimulus();
      checkOutput("stall pop no early grant", 32'(grantLog.size()), 32'd4);
      applyStimulus();
      checkOutput("stall credit regrant", 32'(grantLog.size()), 32'd5);
      runCycles(6);
      if (grantLog.size() > 4) checkOutput("stall next addr", grantLog[4], 32'h10);
      checkOutput("stall deliveries", 32'(pcLog.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (pcLog.size() > i) checkOutput("stall inst_pc", pcLog[i], 32'(4 * i));
      end

      // Redirect with two requests in flight on a 3-cycle memory
      doReset();
      fetchEn = 1'b1;
      gntOn   = 1'b1;
      latency = 3;
      runCycles(2);
      redirectCycle(32'h0000_1003);
      checkOutput("redir no grant in T", 32'(grantLog.size()), 32'd2);
      checkOutput("redir imem_addr", imemBus.addr, 32'h0000_1000);
      runCycles(12);
      if (grantLog.size() > 2) checkOutput("redir granted target", grantLog[2], 32'h0000_1000);
      if (pcLog.size() > 0) begin
         checkOutput("redir first inst_pc", pcLog[0], 32'h0000_1000);
         checkOutput("redir first inst", instLog[0], memWord(32'h0000_1000));
      end else checkOutput("redir delivered any", 32'(pcLog.size()), 32'd1);
      if (pcLog.size() > 1) checkOutput("redir second inst_pc", pcLog[1], 32'h0000_1004);

      // Redirect coinciding with a response and a pop; one stale request left to drop
      doReset();
      fetchEn = 1'b1;
      gntOn   = 1'b1;
      latency = 2;
      runCycles(3);
      checkOutput("coinc head valid", 32'(instBus.valid), 32'h1);
      redirectCycle(32'h0000_0400);
      checkOutput("coinc flushed", 32'(instBus.valid), 32'h0);
      applyStimulus();
      checkOutput("coinc stale dropped", 32'(instBus.valid), 32'h0);
      runCycles(8);
      checkOutput("coinc deliveries", 32'(pcLog.size() >= 3), 32'h1);
      if (pcLog.size() > 2) begin
         checkOutput("coinc pre pc", pcLog[0], 32'h0);
         checkOutput("coinc target pc", pcLog[1], 32'h0000_0400);
         checkOutput("coinc target inst", instLog[1], memWord(32'h0000_0400));
         checkOutput("coinc next pc", pcLog[2], 32'h0000_0404);
      end

      // Back-to-back redirects with three requests in flight
      doReset();
      fetchEn = 1'b1;
      gntOn   = 1'b1;
      latency = 3;
      runCycles(3);
      redirectCycle(32'h0000_0200);
      redirectCycle(32'h0000_0300);
      runCycles(10);
      begin
         int hits = 0;
         foreach (grantLog[i]) if (grantLog[i] == 32'h0000_0200) hits++;
         checkOutput("b2b no 0x200 grant", 32'(hits), 32'd0);
      end
      if (grantLog.size() > 3) checkOutput("b2b granted target", grantLog[3], 32'h0000_0300);
      if (pcLog.size() > 1) begin
         checkOutput("b2b first inst_pc", pcLog[0], 32'h0000_0300);
         checkOutput("b2b second inst_pc", pcLog[1], 32'h0000_0304);
         checkOutput("b2b first inst", instLog[0], memWord(32'h0000_0300));
      end else checkOutput("b2b deliveries", 32'(pcLog.size()), 32'd2);

      // Address wrap plus a five-cycle fetch_en gap
      doReset();
      fetchEn = 1'b1;
      gntOn   = 1'b1;
      latency = 2;
      redirectCycle(32'hFFFF_FFFE);
      runCycles(4);
      checkOutput("gap grants before", 32'(grantLog.size()), 32'd4);
      fetchEn = 1'b0;
      runCycles(5);
      checkOutput("gap grants during", 32'(grantLog.size()), 32'd4);
      fetchEn = 1'b1;
      runCycles(12);
      if (grantLog.size() > 1) begin
         checkOutput("wrap first addr", grantLog[0], 32'hFFFF_FFFC);
         checkOutput("wrap second addr", grantLog[1], 32'h0000_0000);
      end
      checkOutput("gap deliveries", 32'(pcLog.size() >= 12), 32'h1);
      for (int i = 0; i < pcLog.size(); i++) begin
         checkOutput("gap inst_pc", pcLog[i], 32'hFFFF_FFFC + 32'(4 * i));
         checkOutput("gap inst", instLog[i], memWord(32'hFFFF_FFFC + 32'(4 * i)));
      end
      for (int i = 0; i < grantLog.size(); i++) begin
         checkOutput("gap addr", grantLog[i], 32'hFFFF_FFFC + 32'(4 * i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
